// File: rtl/clb_multi_ble.sv
// Multi-BLE configurable logic block: N K-input LUTs with optional output flip-flops,
// sharing one serial configuration chain with session bit counting and error flagging.
module clb_multi_ble #(
  parameter int K = 4,
  parameter int N = 2
) (
  input  logic           clb_clk,
  input  logic           clb_rst,
  input  logic           prog_en,
  input  logic           prog_in,
  output logic           prog_out,
  input  logic           clb_ce,
  input  logic [N*K-1:0] clb_input,
  output logic [N-1:0]   clb_output,
  output logic           cfg_done,
  output logic           cfg_err
);

  localparam int T  = 1 << K;
  localparam int W  = T + 1;
  localparam int L  = N * W;
  localparam int CW = $clog2(L + 1);
  localparam logic [CW-1:0] LCNT = CW'(L);

  logic [L-1:0]  r_cfg;
  logic [N-1:0]  r_ff;
  logic [CW-1:0] r_bitCnt;
  logic          r_cfgDone;
  logic          r_cfgErr;
  logic          r_progEnD;

  logic          w_sessStart;
  logic          w_sessEnd;
  logic [N-1:0]  w_lut;
  logic [N-1:0]  w_mode;

  assign w_sessStart = prog_en & ~r_progEnD;
  assign w_sessEnd   = ~prog_en & r_progEnD;

  // Serial chain: new bits enter at the top, cfg[0] is the bit about to leave.
  always_ff @(posedge clb_clk) begin
    if (clb_rst) begin
      r_cfg <= '0;
    end else if (prog_en) begin
      r_cfg <= {prog_in, r_cfg[L-1:1]};
    end
  end

  always_ff @(posedge clb_clk) begin
    if (clb_rst) begin
      r_progEnD <= 1'b0;
      r_bitCnt  <= '0;
      r_cfgDone <= 1'b0;
      r_cfgErr  <= 1'b0;
    end else begin
      r_progEnD <= prog_en;
      if (w_sessStart) begin
        r_bitCnt  <= CW'(1);
        r_cfgDone <= 1'b0;
        r_cfgErr  <= 1'b0;
      end else if (prog_en) begin
        // Counter saturates at L; any further bit marks the session over-length.
        if (r_bitCnt < LCNT) begin
          r_bitCnt <= r_bitCnt + CW'(1);
        end else begin
          r_cfgErr <= 1'b1;
        end
      end else if (w_sessEnd) begin
        r_cfgDone <= (r_bitCnt == LCNT) && !r_cfgErr;
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_ble
    logic [T-1:0] w_truth;
    logic [K-1:0] w_sel;

    assign w_truth     = r_cfg[gi*W +: T];
    assign w_sel       = clb_input[gi*K +: K];
    assign w_lut[gi]   = w_truth[w_sel];
    assign w_mode[gi]  = r_cfg[gi*W + T];
  end

  // Flip-flops freeze while the chain is being shifted, so a reload keeps their state.
  always_ff @(posedge clb_clk) begin
    if (clb_rst) begin
      r_ff <= '0;
    end else if (clb_ce && !prog_en) begin
      r_ff <= w_lut;
    end
  end

  assign clb_output = prog_en ? '0 : ((w_mode & r_ff) | (~w_mode & w_lut));
  assign prog_out   = r_cfg[0];
  assign cfg_done   = r_cfgDone;
  assign cfg_err    = r_cfgErr;

endmodule

// File: tb/tb_clb_multi_ble.sv
// Directed self-checking bench for clb_multi_ble with K=4, N=2 (34-bit chain).
module tb_clb_multi_ble;

  localparam int K = 4;
  localparam int N = 2;
  localparam int L = 34;

  logic           clb_clk = 1'b0;
  logic           clb_rst;
  logic           prog_en;
  logic           prog_in;
  logic           prog_out;
  logic           clb_ce;
  logic [N*K-1:0] clb_input;
  logic [N-1:0]   clb_output;
  logic           cfg_done;
  logic           cfg_err;

  int checks   = 0;
  int failures = 0;

  logic [63:0] vecComb;
  logic [63:0] vecReg;
  logic [63:0] vec36;

  clb_multi_ble #(.K(K), .N(N)) dut (
    .clb_clk   (clb_clk),
    .clb_rst   (clb_rst),
    .prog_en   (prog_en),
    .prog_in   (prog_in),
    .prog_out  (prog_out),
    .clb_ce    (clb_ce),
    .clb_input (clb_input),
    .clb_output(clb_output),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err)
  );

  always #5 clb_clk = ~clb_clk;

  task automatic tick();
    @(posedge clb_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Shifts nbits of vec LSB-first, then drops prog_en and clocks the session-end edge.
  task automatic applyStimulus(input logic [63:0] vec, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      prog_en = 1'b1;
      prog_in = vec[i];
      tick();
    end
    prog_en = 1'b0;
    prog_in = 1'b0;
    tick();
  endtask

  initial begin
    vecComb = {30'b0, 1'b0, 16'h6996, 1'b0, 16'h8000};
    vecReg  = {30'b0, 1'b1, 16'h6996, 1'b0, 16'h8000};
    vec36   = {vecComb[61:0], 2'b01};

    clb_rst   = 1'b1;
    prog_en   = 1'b0;
    prog_in   = 1'b0;
    clb_ce    = 1'b0;
    clb_input = '0;
    tick();
    tick();
    clb_rst = 1'b0;

    // Reset in the middle of a 10-bit session
    for (int i = 0; i < 10; i++) begin
      prog_en = 1'b1;
      prog_in = 1'b1;
      tick();
    end
    clb_rst = 1'b1;
    tick();
    tick();
    clb_rst   = 1'b0;
    prog_en   = 1'b0;
    prog_in   = 1'b0;
    clb_input = 8'hFF;
    #1;
    checkOutput("rst_prog_out", 64'(prog_out), 64'(1'b0));
    checkOutput("rst_output", 64'(clb_output), 64'(2'b00));
    checkOutput("rst_done", 64'(cfg_done), 64'(1'b0));
    checkOutput("rst_err", 64'(cfg_err), 64'(1'b0));
    tick();
    checkOutput("rst_done_hold", 64'(cfg_done), 64'(1'b0));

    // Combinational load: AND4 on BLE0, XOR4 on BLE1
    clb_input = '0;
    applyStimulus(vecComb, L);
    checkOutput("comb_done", 64'(cfg_done), 64'(1'b1));
    checkOutput("comb_err", 64'(cfg_err), 64'(1'b0));
    for (int v = 0; v < 256; v++) begin
      logic [7:0] vb;
      vb = 8'(v);
      clb_input = vb;
      #1;
      checkOutput("comb_and4", 64'(clb_output[0]), 64'(vb[3:0] == 4'hF));
      checkOutput("comb_xor4", 64'(clb_output[1]),
                  64'(vb[4] ^ vb[5] ^ vb[6] ^ vb[7]));
    end
    tick();
    checkOutput("comb_done_hold", 64'(cfg_done), 64'(1'b1));

    // Registered mode on BLE1
    clb_input = 8'h00;
    applyStimulus(vecReg, L);
    checkOutput("reg_done", 64'(cfg_done), 64'(1'b1));
    clb_ce = 1'b1;
    tick();
    checkOutput("reg_init", 64'(clb_output[1]), 64'(1'b0));
    clb_input = 8'h10;
    #1;
    checkOutput("reg_latency", 64'(clb_output[1]), 64'(1'b0));
    tick();
    checkOutput("reg_rise", 64'(clb_output[1]), 64'(1'b1));
    clb_ce    = 1'b0;
    clb_input = 8'h30;
    #1;
    checkOutput("reg_ce_off_now", 64'(clb_output[1]), 64'(1'b1));
    tick();
    checkOutput("reg_ce_off_hold", 64'(clb_output[1]), 64'(1'b1));

    // Programming gate: one-bit session while outputs are 11
    clb_input = 8'h3F;
    #1;
    checkOutput("gate_before", 64'(clb_output), 64'(2'b11));
    prog_en = 1'b1;
    prog_in = 1'b1;
    clb_ce  = 1'b1;
    #1;
    checkOutput("gate_forced", 64'(clb_output), 64'(2'b00));
    tick();
    checkOutput("gate_still", 64'(clb_output), 64'(2'b00));
    prog_en = 1'b0;
    prog_in = 1'b0;
    clb_ce  = 1'b0;
    #1;
    checkOutput("gate_release", 64'(clb_output), 64'(2'b10));
    tick();
    checkOutput("pulse_done", 64'(cfg_done), 64'(1'b0));
    checkOutput("pulse_err", 64'(cfg_err), 64'(1'b0));

    // Over-length session of 36 bits
    clb_input = 8'h0F;
    for (int i = 0; i < 36; i++) begin
      prog_en = 1'b1;
      prog_in = vec36[i];
      #1;
      if (i == 5) checkOutput("over_gated", 64'(clb_output), 64'(2'b00));
      if (i == 34) checkOutput("over_out_bit0", 64'(prog_out), 64'(1'b1));
      if (i == 35) checkOutput("over_out_bit1", 64'(prog_out), 64'(1'b0));
      tick();
      if (i == 33) checkOutput("over_err_34", 64'(cfg_err), 64'(1'b0));
      if (i == 34) checkOutput("over_err_35", 64'(cfg_err), 64'(1'b1));
    end
    prog_en = 1'b0;
    prog_in = 1'b0;
    tick();
    checkOutput("over_done", 64'(cfg_done), 64'(1'b0));
    checkOutput("over_err_end", 64'(cfg_err), 64'(1'b1));
    checkOutput("over_cfg_kept", 64'(clb_output), 64'(2'b01));

    // Correct session clears the error
    applyStimulus(vecComb, L);
    checkOutput("fix_done", 64'(cfg_done), 64'(1'b1));
    checkOutput("fix_err", 64'(cfg_err), 64'(1'b0));
    clb_input = 8'h7F;
    #1;
    checkOutput("fix_output", 64'(clb_output), 64'(2'b11));

    // Short session of 33 bits
    applyStimulus(vecComb, L - 1);
    checkOutput("short_done", 64'(cfg_done), 64'(1'b0));
    checkOutput("short_err", 64'(cfg_err), 64'(1'b0));
    tick();
    tick();
    checkOutput("short_done_hold", 64'(cfg_done), 64'(1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/clb_multi_ble.md
Name: clb_multi_ble

Overview:
- Parametrised successor to the single-LUT CLB: N basic logic elements (BLEs), each a K-input LUT plus an optional output flip-flop.
- All BLEs share one serial configuration chain, clocked by the single fabric clock and qualified by prog_en.
- Adds a bit counter that reports configuration completion and over-length bitstreams.
- Adds a fabric clock-enable and output gating during programming; sits as one tile in the fabric array.

Parameters:
- K, 4, LUT input count per BLE (2..6).
- N, 2, number of BLEs (1..8).
- Derived, not overridable: W = 2^K + 1 config bits per BLE; L = N*W total chain length; CW = clog2(L+1) counter width.

Ports:
- clb_clk  in  1  single clock; all state updates on rising edge.
- clb_rst  in  1  synchronous, active-high reset.
- prog_en  in  1  1 = shift one config bit per cycle.
- prog_in  in  1  serial config data.
- prog_out  out  1  serial chain output (cfg[0]) for daisy-chaining/readback.
- clb_ce  in  1  flip-flop clock enable for registered BLEs.
- clb_input  in  N*K  BLE i uses clb_input[i*K +: K].
- clb_output  out  N  BLE outputs.
- cfg_done  out  1  exactly L bits were loaded in the last programming session.
- cfg_err  out  1  more than L bits were shifted in the current/last session.

Behaviour:
- Reset (clb_rst=1 at a clock edge):
  - cfg[L-1:0], BLE flip-flops, bit_cnt, cfg_done and cfg_err all become 0; prog_en_d becomes 0.
  - Reset overrides every other event, including mid-programming. An interrupted session is discarded and must restart from bit 0.
- Shift: each edge with prog_en=1, cfg <= {prog_in, cfg[L-1:1]}. The first bit shifted ends at cfg[0] after L shifts.
- prog_out = cfg[0] combinationally; the bit leaving the chain is visible before the edge that drops it.
- BLE i config:
  - Truth table T_i = cfg[i*W +: 2^K]. LUT value = T_i[clb_input[i*K +: K]].
  - Mode bit M_i = cfg[i*W + 2^K]: 0 = combinational, 1 = registered.
- Combinational mode: clb_output[i] follows the LUT value with zero cycle latency.
- Registered mode:
  - ff_i <= LUT value on an edge where clb_ce=1 and prog_en=0.
  - Otherwise ff_i holds. clb_output[i] = ff_i, giving 1-cycle latency.
- Output gating: while prog_en=1, clb_output is forced to all-zero, in both modes. Flip-flops hold their values during programming.
- Session tracking: prog_en_d is the registered copy of prog_en. A session starts on a cycle with prog_en=1 and prog_en_d=0. On that edge:
  - bit_cnt <= 1;
  - cfg_done <= 0;
  - cfg_err <= 0.
- Within a session (prog_en=1, prog_en_d=1):
  - if bit_cnt < L, bit_cnt increments;
  - if bit_cnt == L, bit_cnt holds (saturates) and cfg_err <= 1 (sticky).
  - Shifting still occurs in both cases; extra bits push the earliest bits out of prog_out.
- Session end (prog_en=0, prog_en_d=1): cfg_done <= (bit_cnt == L) && !cfg_err. cfg_done is visible one cycle after prog_en falls.
- Between sessions, cfg_done, cfg_err and bit_cnt hold. The counter never wraps.
- Edge cases:
  - prog_en pulsed for a single cycle counts as a 1-bit session: cfg_done=0 unless L==1 (impossible for legal K).
  - Changing clb_ce has no effect while prog_en=1.
  - Mode bit changes take effect immediately after each shift. Flip-flop contents are not cleared by reprogramming.

Test Plan (K=4, N=2, L=34):
- Reset: assert clb_rst 2 cycles during a 10-bit session, deassert -> cfg=0, clb_output=00, bit_cnt=0, cfg_done=0, cfg_err=0.
- Combinational load: BLE0 table 0x8000 (AND4), M0=0; BLE1 table 0x6996 (XOR4), M1=0. Shift 34 bits LSB-first, drop prog_en. Then:
  - cfg_done=1 the next cycle;
  - sweep clb_input 0x00..0xFF -> clb_output[0]=1 only when low nibble=0xF;
  - clb_output[1] = parity of high nibble, same cycle.
- Registered mode: reload with M1=1, clb_ce=1. Drive high nibble 0x1 -> clb_output[1] rises one edge later. clb_ce=0 then high nibble 0x3 -> output holds 1.
- Programming gate: set prog_en=1 mid-operation with outputs at 11 -> clb_output=00 immediately. Flip-flop value 1 reappears after prog_en falls if M1 is still 1.
- Over-length: shift 36 bits -> cfg_err=1 on the 35th shift edge and cfg_done=0 after the fall. prog_out emitted the first 2 shifted bits. A following correct 34-bit session clears cfg_err and sets cfg_done=1.
- Short session: shift 33 bits -> cfg_done=0 and cfg_err=0 after prog_en falls.
